fetch_align: RTL and testbench
==============================

Name: fetch_align

Overview:
- Instruction fetch sequencer that sits between the 32-bit instruction memory port and the decode stage.
- Issues word-aligned memory reads and keeps a one-halfword carry buffer.
- Presents one complete instruction (16-bit RVC or 32-bit, any halfword alignment) per handshake, with its PC and a length flag.
- Handles control-flow redirects from execute, including redirects that arrive while a read is outstanding.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- ADDR_W, 32, width of PC and memory address.

Ports:
- I_clk  in  1  clock.
- I_rst  in  1  reset; one clock; reset is synchronous and active-high.
- I_redirect  in  1  load a new PC; flushes all buffered state.
- I_redirect_pc  in  ADDR_W  redirect target; bit 0 is ignored (forced to 0).
- O_mem_req  out  1  read request to instruction memory.
- O_mem_addr  out  ADDR_W  word address; bits [1:0] are always 00.
- I_mem_ack  in  1  read complete; I_mem_data is valid in the same cycle.
- I_mem_data  in  32  read data.
- O_valid  out  1  instruction available to decode.
- I_ready  in  1  decode accepts the instruction.
- O_instr  out  32  instruction; a 16-bit instruction is zero-extended in [31:16].
- O_pc  out  ADDR_W  PC of O_instr.
- O_is16  out  1  1 = compressed encoding (low bits != 2'b11).
- O_fault  out  1  see Optional Feature; 0 when the feature is enabled.

Behaviour:
- Reset values: O_valid=0, O_mem_req=0, O_instr=0, O_pc=RESET_PC, O_is16=0, O_fault=0. The halfword buffer is empty (hb_v=0), pc=RESET_PC, state=S_REQ.
- Internal state: pc, hb[15:0] with valid hb_v, drop flag, state in {S_REQ, S_WAIT, S_OUT}.
- S_REQ:
  - O_mem_req=1 and O_mem_addr={pc[31:2],2'b00}, or the next word address when hb_v=1 and the carried half starts a 32-bit instruction.
  - Go to S_WAIT on the next edge.
- S_WAIT:
  - O_mem_req is held with a stable address until I_mem_ack. Only one read is outstanding at a time.
  - On ack, the instruction is assembled in the same cycle as ack; go to S_OUT.
- Assembly:
  - hb_v=1 and hb[1:0]==11: instr={data[15:0],hb}; hb<=data[31:16], hb_v=1.
  - pc[1]=0 and data[1:0]!=11: 16-bit instruction = data[15:0]; hb<=data[31:16], hb_v=1.
  - pc[1]=0 and data[1:0]==11: 32-bit instruction = data; hb_v=0.
  - pc[1]=1 and hb_v=0: use data[31:16]. If it is compressed, output it. Otherwise hb<=data[31:16], hb_v=1, and fetch again (S_REQ) without raising O_valid.
- S_OUT:
  - O_valid=1. O_instr, O_pc and O_is16 hold stable until I_ready.
  - On O_valid&&I_ready: pc <= pc+2 (16-bit) or pc+4 (32-bit), modulo 2^ADDR_W.
  - Next state after the handshake:
    - hb_v=1 and hb is compressed: present hb directly next cycle (no memory access); hb_v<=0; stay in S_OUT.
    - Otherwise: go to S_REQ.
- Throughput: a 32-bit aligned stream yields one instruction per 3 cycles with zero-wait memory. A pair of 16-bit instructions costs one fetch.
- Redirect (highest priority, any state):
  - pc<={I_redirect_pc[31:1],1'b0}; hb_v<=0; O_valid<=0 in the next cycle; any offered instruction is discarded even if I_ready is high in that cycle.
  - In S_WAIT without ack: set drop, keep the request up until ack, discard that data, then go to S_REQ with the new pc.
  - In S_WAIT with ack in the same cycle: discard the data and go to S_REQ.
  - Back-to-back redirects: the last one wins.
- Reset mid-transfer: everything returns to reset values in the next cycle; a late ack with no request outstanding is ignored.
- PC wrap: 32'hFFFFFFFE + 2 = 0; a 32-bit instruction spanning the wrap fetches word 0.

Optional Feature:
- FETCH_ALIGN_RVC_EN.
- Defined: full compressed support as described above; O_fault is tied to 0.
- Undefined:
  - hb logic is removed; every fetch yields data as a 32-bit instruction; O_is16=0; pc advances by 4.
  - Redirect targets have bits [1:0] forced to 0.
  - A word with data[1:0]!=11 is presented with O_fault=1; pc still advances by 4.

Decomposition:
- general_definitions.vh holds:
  - FA_S_REQ/FA_S_WAIT/FA_S_OUT encodings (2 bits).
  - LEN32_BITS = 2'b11.
  - INSTR_NOP = 32'h00000013.
- One natural sub-module: fetch_len, a combinational length detector and assembler. Inputs: pc[1], hb, hb_v, data. Outputs: instr, is16, need_more.

Test Plan:
- Reset, memory returns 32'h00500093 at addr 0 -> O_instr=32'h00500093, O_pc=0, O_is16=0; next O_mem_addr=4.
- Word at 0 = 32'h00850513 is a 32-bit instruction; word 0 = {16'h4505,16'h0505} -> two outputs: 16'h0505 at pc 0, then 16'h4505 at pc 2; only one memory read.
- Spanning: word 0={16'h0093,16'h0505}, word 4={16'h....,16'h0050} -> 16'h0505 @0, then 32'h00500093 @2.
- Redirect to 32'h00000102 while S_WAIT for addr 8 -> ack data for 8 discarded; next O_mem_addr=32'h100; upper half used.
- O_valid held with I_ready=0 for 5 cycles -> O_instr/O_pc unchanged; no new O_mem_req.
- Without FETCH_ALIGN_RVC_EN, word 32'h00004505 -> O_fault=1, O_pc=0, next pc=4.

Source files
------------

// File: rtl/fetch_align_pkg.sv
// fetch_align_pkg: shared encodings for the instruction fetch aligner.
//   fa_state_e  - sequencer state encoding (2 bits)
//   LEN32_BITS  - low-bit pattern marking a 32-bit encoding
//   INSTR_NOP   - canonical 32-bit nop (addi x0,x0,0)
//   is_rvc()    - true when a halfword starts a compressed instruction
package fetch_align_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    FA_S_REQ  = 2'b00,
    FA_S_WAIT = 2'b01,
    FA_S_OUT  = 2'b10
  } fa_state_e;

  localparam logic [1:0]        LEN32_BITS = 2'b11;
  localparam logic [WORD_W-1:0] INSTR_NOP  = 32'h00000013;

  function automatic logic is_rvc(input logic [HALF_W-1:0] half);
    return half[1:0] != LEN32_BITS;
  endfunction

endpackage

// File: rtl/fetch_len.sv
// fetch_len: combinational length detector and instruction assembler.
//   pc1       - bit 1 of the fetch PC (upper-half start)
//   hb, hb_v  - carried halfword and its valid flag
//   data      - memory word just returned
//   instr     - assembled instruction (16-bit zero-extended)
//   is16      - assembled instruction is compressed
//   need_more - upper half starts a 32-bit instruction; another word is needed
module fetch_len
  import fetch_align_pkg::*;
(
  input  logic              pc1,
  input  logic [HALF_W-1:0] hb,
  input  logic              hb_v,
  input  logic [WORD_W-1:0] data,
  output logic [WORD_W-1:0] instr,
  output logic              is16,
  output logic              need_more
);

  // Carried upper half of a 32-bit instruction takes precedence over pc1.
  always_comb begin
    instr     = '0;
    is16      = 1'b0;
    need_more = 1'b0;
    if (hb_v && !is_rvc(hb)) begin
      instr = {data[15:0], hb};
    end else if (!pc1) begin
      if (is_rvc(data[15:0])) begin
        instr = {16'h0000, data[15:0]};
        is16  = 1'b1;
      end else begin
        instr = data;
      end
    end else if (is_rvc(data[31:16])) begin
      instr = {16'h0000, data[31:16]};
      is16  = 1'b1;
    end else begin
      need_more = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_align.sv
// fetch_align: instruction fetch sequencer between a 32-bit instruction
// memory port and decode. Issues word-aligned reads, one outstanding at a
// time, and presents one whole instruction per valid/ready handshake.
//   I_clk, I_rst                 - clock, synchronous active-high reset
//   I_redirect, I_redirect_pc    - load new PC, flush buffered state
//   O_mem_req/O_mem_addr         - word read request (addr[1:0] = 00)
//   I_mem_ack/I_mem_data         - read completion with data
//   O_valid/I_ready              - decode handshake
//   O_instr/O_pc/O_is16/O_fault  - presented instruction and attributes
// Build option FETCH_ALIGN_RVC_EN: when defined, compressed instructions at
// any halfword alignment are supported via a one-halfword carry buffer and
// O_fault is 0. When undefined every word is one 32-bit instruction and a
// word with compressed low bits is presented with O_fault=1.
module fetch_align
  import fetch_align_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_redirect,
  input  logic [ADDR_W-1:0] I_redirect_pc,
  output logic              O_mem_req,
  output logic [ADDR_W-1:0] O_mem_addr,
  input  logic              I_mem_ack,
  input  logic [WORD_W-1:0] I_mem_data,
  output logic              O_valid,
  input  logic              I_ready,
  output logic [WORD_W-1:0] O_instr,
  output logic [ADDR_W-1:0] O_pc,
  output logic              O_is16,
  output logic              O_fault
);

  fa_state_e         state;
  logic [ADDR_W-1:0] pc;
  logic              drop;

  logic [ADDR_W-1:0] word_addr_c;
  logic [ADDR_W-1:0] req_addr_c;
  logic [ADDR_W-1:0] redir_pc_c;
  logic [ADDR_W-1:0] pc_next_c;
  logic [WORD_W-1:0] asm_instr_c;
  logic [WORD_W-1:0] hb_instr_c;
  logic              asm_is16_c;
  logic              need_more_c;
  logic              hb_pop_c;
  logic              fault_c;

  assign word_addr_c = {pc[ADDR_W-1:2], 2'b00};
  assign pc_next_c   = pc + (O_is16 ? ADDR_W'(2) : ADDR_W'(4));

`ifdef FETCH_ALIGN_RVC_EN
  logic [HALF_W-1:0] hb;
  logic              hb_v;
  logic              hb_load_c;
  logic              ack_take_c;
  logic              unused_c;

  fetch_len u_len (
    .pc1       (pc[1]),
    .hb        (hb),
    .hb_v      (hb_v),
    .data      (I_mem_data),
    .instr     (asm_instr_c),
    .is16      (asm_is16_c),
    .need_more (need_more_c)
  );

  assign unused_c    = I_redirect_pc[0];
  assign redir_pc_c  = {I_redirect_pc[ADDR_W-1:1], 1'b0};
  // A carried 32-bit start needs its upper half from the following word.
  assign req_addr_c  = (hb_v && !is_rvc(hb)) ? word_addr_c + ADDR_W'(4) : word_addr_c;
  assign ack_take_c  = (state == FA_S_WAIT) && I_mem_ack && !drop && !I_redirect;
  assign hb_pop_c    = (state == FA_S_OUT) && I_ready && !I_redirect && hb_v && is_rvc(hb);
  assign hb_instr_c  = {16'h0000, hb};
  assign fault_c     = 1'b0;
  // Keep the upper half whenever the lower half (or carry) formed the output.
  assign hb_load_c   = (hb_v && !is_rvc(hb)) || (!pc[1] && asm_is16_c) || need_more_c;

  // Halfword carry buffer.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      hb   <= '0;
      hb_v <= 1'b0;
    end else if (I_redirect) begin
      hb_v <= 1'b0;
    end else if (ack_take_c) begin
      hb_v <= hb_load_c;
      if (hb_load_c) hb <= I_mem_data[31:16];
    end else if (hb_pop_c) begin
      hb_v <= 1'b0;
    end
  end
`else
  logic [1:0] unused_c;

  assign unused_c    = I_redirect_pc[1:0];
  assign redir_pc_c  = {I_redirect_pc[ADDR_W-1:2], 2'b00};
  assign req_addr_c  = word_addr_c;
  assign asm_instr_c = I_mem_data;
  assign asm_is16_c  = 1'b0;
  assign need_more_c = 1'b0;
  assign hb_pop_c    = 1'b0;
  assign hb_instr_c  = '0;
  assign fault_c     = I_mem_data[1:0] != LEN32_BITS;
`endif

  // Fetch sequencer; redirect overrides every state.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state      <= FA_S_REQ;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      O_mem_req  <= 1'b0;
      O_mem_addr <= '0;
      O_valid    <= 1'b0;
      O_instr    <= '0;
      O_pc       <= RESET_PC;
      O_is16     <= 1'b0;
      O_fault    <= 1'b0;
    end else if (I_redirect) begin
      pc      <= redir_pc_c;
      O_valid <= 1'b0;
      if (state == FA_S_WAIT && !I_mem_ack) begin
        // Read still in flight: keep requesting, discard its data later.
        drop <= 1'b1;
      end else begin
        drop      <= 1'b0;
        O_mem_req <= 1'b0;
        state     <= FA_S_REQ;
      end
    end else begin
      case (state)
        FA_S_REQ: begin
          O_mem_req  <= 1'b1;
          O_mem_addr <= req_addr_c;
          state      <= FA_S_WAIT;
        end
        FA_S_WAIT: begin
          if (I_mem_ack) begin
            O_mem_req <= 1'b0;
            drop      <= 1'b0;
            if (drop || need_more_c) begin
              state <= FA_S_REQ;
            end else begin
              O_valid <= 1'b1;
              O_instr <= asm_instr_c;
              O_pc    <= pc;
              O_is16  <= asm_is16_c;
              O_fault <= fault_c;
              state   <= FA_S_OUT;
            end
          end
        end
        FA_S_OUT: begin
          if (I_ready) begin
            pc <= pc_next_c;
            if (hb_pop_c) begin
              // Carried compressed half goes out with no memory access.
              O_instr <= hb_instr_c;
              O_pc    <= pc_next_c;
              O_is16  <= 1'b1;
              O_fault <= 1'b0;
            end else begin
              O_valid <= 1'b0;
              state   <= FA_S_REQ;
            end
          end
        end
        default: state <= FA_S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// tb_fetch_align: directed self-checking bench for fetch_align with a
// word-addressed memory responder of programmable ack latency.
module tb_fetch_align;
  import fetch_align_pkg::*;

  logic        I_clk;
  logic        I_rst;
  logic        I_redirect;
  logic [31:0] I_redirect_pc;
  logic        O_mem_req;
  logic [31:0] O_mem_addr;
  logic        I_mem_ack;
  logic [31:0] I_mem_data;
  logic        O_valid;
  logic        I_ready;
  logic [31:0] O_instr;
  logic [31:0] O_pc;
  logic        O_is16;
  logic        O_fault;

  logic [31:0] mem [0:127];
  logic        resp_ack;
  logic        stray_ack;
  logic [31:0] last_addr;
  int          ack_delay;
  int          wait_cnt;
  int          nreads;
  int          n0;
  int          vectors;
  int          errors;

  assign I_mem_ack = resp_ack | stray_ack;

  fetch_align dut (
    .I_clk         (I_clk),
    .I_rst         (I_rst),
    .I_redirect    (I_redirect),
    .I_redirect_pc (I_redirect_pc),
    .O_mem_req     (O_mem_req),
    .O_mem_addr    (O_mem_addr),
    .I_mem_ack     (I_mem_ack),
    .I_mem_data    (I_mem_data),
    .O_valid       (O_valid),
    .I_ready       (I_ready),
    .O_instr       (O_instr),
    .O_pc          (O_pc),
    .O_is16        (O_is16),
    .O_fault       (O_fault)
  );

  initial begin
    I_clk = 1'b0;
    forever #5 I_clk = ~I_clk;
  end

  // Memory responder: acks after ack_delay cycles of visible request.
  initial begin
    resp_ack   = 1'b0;
    I_mem_data = '0;
    wait_cnt   = 0;
    nreads     = 0;
    last_addr  = '0;
    forever begin
      @(negedge I_clk);
      if (O_mem_req === 1'b1 && I_rst === 1'b0) begin
        if (wait_cnt >= ack_delay) begin
          resp_ack   = 1'b1;
          I_mem_data = mem[O_mem_addr[8:2]];
          last_addr  = O_mem_addr;
          nreads++;
          wait_cnt   = 0;
        end else begin
          resp_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        resp_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (O_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    assert (O_valid === 1'b1) else begin
      errors++;
      $error("FAIL %s: O_valid observed %b expected 1 within 40 cycles", tag, O_valid);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic is16, input logic fault);
    wait_valid({tag, "_valid"});
    chk({tag, "_instr"}, O_instr, instr);
    chk({tag, "_pc"}, O_pc, pc);
    chk({tag, "_is16"}, 32'(O_is16), 32'(is16));
    chk({tag, "_fault"}, 32'(O_fault), 32'(fault));
  endtask

  task automatic take();
    I_ready = 1'b1;
    tick();
    I_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    I_redirect    = 1'b1;
    I_redirect_pc = target;
    tick();
    I_redirect    = 1'b0;
  endtask

  initial begin
    vectors       = 0;
    errors        = 0;
    I_rst         = 1'b1;
    I_redirect    = 1'b0;
    I_redirect_pc = '0;
    I_ready       = 1'b0;
    stray_ack     = 1'b0;
    ack_delay     = 0;
    for (int i = 0; i < 128; i++) mem[i] = INSTR_NOP;
`ifdef FETCH_ALIGN_RVC_EN
    mem[0]   = 32'h45050505;
    mem[1]   = 32'h00930505;
    mem[2]   = 32'h00010050;
    mem[3]   = 32'h00850513;
    mem[4]   = 32'h0badc0d3;
    mem[64]  = 32'h45051234;
    mem[65]  = 32'h00500093;
    mem[66]  = 32'h0513beef;
    mem[67]  = 32'h45050085;
    mem[127] = 32'h00930000;
`else
    mem[0]   = 32'h00500093;
    mem[1]   = 32'h00850513;
    mem[2]   = 32'h00004505;
    mem[4]   = 32'h0badc0d3;
    mem[64]  = 32'h00a00113;
    mem[127] = 32'h00100073;
`endif
    tick();
    tick();
    chk("rst_valid", 32'(O_valid), 32'd0);
    chk("rst_req", 32'(O_mem_req), 32'd0);
    chk("rst_instr", O_instr, 32'h0);
    chk("rst_pc", O_pc, 32'h0);
    chk("rst_is16", 32'(O_is16), 32'd0);
    chk("rst_fault", 32'(O_fault), 32'd0);
    I_rst = 1'b0;

`ifdef FETCH_ALIGN_RVC_EN
    expect_out("c0", 32'h00000505, 32'h0, 1'b1, 1'b0);
    n0 = nreads;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_instr", O_instr, 32'h00000505);
      chk("hold_pc", O_pc, 32'h0);
      chk("hold_req", 32'(O_mem_req), 32'd0);
    end
    take();
    expect_out("c1", 32'h00004505, 32'h2, 1'b1, 1'b0);
    chk("pair_reads", 32'(nreads), 32'(n0));
    take();
    expect_out("c2", 32'h00000505, 32'h4, 1'b1, 1'b0);
    take();
    expect_out("span", 32'h00500093, 32'h6, 1'b0, 1'b0);
    chk("span_addr", last_addr, 32'h8);
    n0 = nreads;
    take();
    expect_out("hbc", 32'h00000001, 32'hA, 1'b1, 1'b0);
    chk("hbc_reads", 32'(nreads), 32'(n0));
    ack_delay = 3;
    take();
    expect_out("a32", 32'h00850513, 32'hC, 1'b0, 1'b0);
    take();
    tick();
    chk("req16", O_mem_addr, 32'h10);
    n0 = nreads;
    redirect(32'h00000102);
    chk("drop_req", 32'(O_mem_req), 32'd1);
    chk("drop_addr", O_mem_addr, 32'h10);
    expect_out("upper", 32'h00004505, 32'h102, 1'b1, 1'b0);
    chk("upper_addr", last_addr, 32'h100);
    chk("upper_reads", 32'(nreads), 32'(n0 + 2));
    take();
    expect_out("after_up", 32'h00500093, 32'h104, 1'b0, 1'b0);
    ack_delay = 0;
    I_ready = 1'b1;
    I_redirect = 1'b1;
    I_redirect_pc = 32'h0;
    tick();
    I_ready = 1'b0;
    chk("flush_valid", 32'(O_valid), 32'd0);
    redirect(32'h0000010A);
    expect_out("need", 32'h00850513, 32'h10A, 1'b0, 1'b0);
    chk("need_addr", last_addr, 32'h10C);
    take();
    expect_out("tail", 32'h00004505, 32'h10E, 1'b1, 1'b0);
    take();
`else
    expect_out("w0", 32'h00500093, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_instr", O_instr, 32'h00500093);
      chk("hold_pc", O_pc, 32'h0);
      chk("hold_req", 32'(O_mem_req), 32'd0);
    end
    take();
    tick();
    chk("next_req", 32'(O_mem_req), 32'd1);
    chk("next_addr", O_mem_addr, 32'h4);
    expect_out("w1", 32'h00850513, 32'h4, 1'b0, 1'b0);
    take();
    expect_out("w2", 32'h00004505, 32'h8, 1'b0, 1'b1);
    ack_delay = 3;
    take();
    tick();
    tick();
    tick();
    chk("wait_req", 32'(O_mem_req), 32'd1);
    chk("wait_addr", O_mem_addr, 32'hC);
    expect_out("nop", 32'h00000013, 32'hC, 1'b0, 1'b0);
    take();
    tick();
    chk("req16", O_mem_addr, 32'h10);
    n0 = nreads;
    redirect(32'h00000102);
    chk("drop_req", 32'(O_mem_req), 32'd1);
    chk("drop_addr", O_mem_addr, 32'h10);
    expect_out("redir", 32'h00a00113, 32'h100, 1'b0, 1'b0);
    chk("redir_addr", last_addr, 32'h100);
    chk("redir_reads", 32'(nreads), 32'(n0 + 2));
    ack_delay = 0;
    I_ready = 1'b1;
    I_redirect = 1'b1;
    I_redirect_pc = 32'h0;
    tick();
    I_ready = 1'b0;
    chk("flush_valid", 32'(O_valid), 32'd0);
    redirect(32'h00000004);
    expect_out("last_wins", 32'h00850513, 32'h4, 1'b0, 1'b0);
    take();
`endif

    // Reset while a read is outstanding, then a stray ack with no request.
    ack_delay = 3;
    tick();
    chk("mid_req", 32'(O_mem_req), 32'd1);
    I_rst = 1'b1;
    tick();
    I_rst = 1'b0;
    chk("mid_rst_req", 32'(O_mem_req), 32'd0);
    chk("mid_rst_valid", 32'(O_valid), 32'd0);
    chk("mid_rst_pc", O_pc, 32'h0);
    ack_delay = 0;
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    chk("stray_req", 32'(O_mem_req), 32'd1);
    chk("stray_addr", O_mem_addr, 32'h0);

`ifdef FETCH_ALIGN_RVC_EN
    expect_out("post_rst", 32'h00000505, 32'h0, 1'b1, 1'b0);
    take();
    redirect(32'hFFFFFFFE);
    chk("wrap_flush", 32'(O_valid), 32'd0);
    expect_out("wrap", 32'h05050093, 32'hFFFFFFFE, 1'b0, 1'b0);
    chk("wrap_addr", last_addr, 32'h0);
    take();
    expect_out("wrap_tail", 32'h00004505, 32'h2, 1'b1, 1'b0);
    take();
`else
    expect_out("post_rst", 32'h00500093, 32'h0, 1'b0, 1'b0);
    take();
    redirect(32'hFFFFFFFE);
    expect_out("wrap", 32'h00100073, 32'hFFFFFFFC, 1'b0, 1'b0);
    take();
    expect_out("wrap0", 32'h00500093, 32'h0, 1'b0, 1'b0);
    chk("wrap_addr", last_addr, 32'h0);
    take();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
